dsc_decoder: RTL and testbench

DSC_DECODER -- requirements
Module: dsc_decoder

---
 rtl/dsc_pkg.sv | 24 ++
 rtl/dsc_decoder_counter.sv | 48 ++++
 rtl/dsc_decoder.sv | 120 ++++++++++++
 tb/tb_dsc_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsc_pkg.sv
// Shared types and width helpers for the stochastic-to-binary decoder.
// The binary result holds NUM_INPUTS*DATA_WIDTH bits; the cycle counter gets one more.
package dsc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_INPUTS = 2;

  function automatic int unsigned binWidth(input int unsigned dataWidth,
                                           input int unsigned numInputs);
    return dataWidth * numInputs;
  endfunction

  function automatic int unsigned cntWidth(input int unsigned dataWidth,
                                           input int unsigned numInputs);
    return dataWidth * numInputs + 1;
  endfunction

endpackage

// File: rtl/dsc_decoder_counter.sv
// Saturating up-counter with synchronous clear; overflow_o pulses on any
// increment that would pass all-ones, and the count then sticks at all-ones.
module dsc_decoder_counter #(
  parameter int WIDTH  = 8,
  parameter int STRIDE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STRIDE_W = WIDTH'(STRIDE);
  localparam logic [WIDTH-1:0] LIMIT    = MAX - STRIDE_W;

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      // Anything above LIMIT would wrap, so clamp and flag instead.
      if (count_q > LIMIT) begin
        count_d    = MAX;
        overflow_o = 1'b1;
      end else begin
        count_d = count_q + STRIDE_W;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dsc_decoder.sv
// Stochastic-number decoder: counts ones in a qualified bit stream until sn_last
// or a programmable length is reached, then holds the result until accepted.
module dsc_decoder
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int CNT_WIDTH  = cntWidth(DATA_WIDTH, NUM_INPUTS)
) (
  input  logic                             gclk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             sn_in,
  input  logic                             sn_valid,
  input  logic                             sn_last,
  input  logic [CNT_WIDTH-1:0]             cycles_override,
  input  logic                             out_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
  output logic [CNT_WIDTH-1:0]             cycle_count,
  output logic                             op_finished,
  output logic                             count_overflow
);

  localparam int BIN_W = binWidth(DATA_WIDTH, NUM_INPUTS);

  state_e state_q;
  logic   finished_q;
  logic   overflow_q;

  logic [BIN_W-1:0]     binCount;
  logic [CNT_WIDTH-1:0] cycCount;
  logic                 binOvf;
  logic                 cycOvf;
  logic                 startOp;
  logic                 accept;
  logic                 cycSat;
  logic                 binInc;
  logic                 hitOverride;
  logic                 terminate;

  assign startOp = (state_q == IDLE) && en;
  assign accept  = (state_q == ACCUM) && en && sn_valid;
  assign cycSat  = (cycCount == '1);

  // A saturated cycle count freezes the ones count too, keeping ones <= cycles.
  assign binInc = accept && sn_in && !cycSat;

  // Override only fires when the count actually steps onto the programmed value.
  assign hitOverride = (cycles_override != '0) && !cycSat &&
                       ((cycCount + CNT_WIDTH'(1)) == cycles_override);
  assign terminate   = accept && (sn_last || hitOverride);

  dsc_decoder_counter #(
    .WIDTH (CNT_WIDTH),
    .STRIDE(1)
  ) u_cycCounter (
    .clk_i     (gclk),
    .rst_i     (rst),
    .clr_i     (startOp),
    .inc_i     (accept),
    .count_o   (cycCount),
    .overflow_o(cycOvf)
  );

  dsc_decoder_counter #(
    .WIDTH (BIN_W),
    .STRIDE(1)
  ) u_binCounter (
    .clk_i     (gclk),
    .rst_i     (rst),
    .clr_i     (startOp),
    .inc_i     (binInc),
    .count_o   (binCount),
    .overflow_o(binOvf)
  );

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q    <= IDLE;
      finished_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            state_q    <= ACCUM;
            overflow_q <= 1'b0;
          end
        end
        ACCUM: begin
          if (!en) begin
            state_q <= IDLE;
          end else begin
            overflow_q <= overflow_q | cycOvf | binOvf;
            if (terminate) begin
              state_q    <= DONE;
              finished_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            finished_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= IDLE;
          finished_q <= 1'b0;
        end
      endcase
    end
  end

  assign bin_data_out   = binCount;
  assign cycle_count    = cycCount;
  assign op_finished    = finished_q;
  assign count_overflow = overflow_q;

endmodule

// File: tb/tb_dsc_decoder.sv
// Directed bench for dsc_decoder: a vector table for the basic flow plus
// hand-written sequences for termination, saturation, reset and hold cases.
module tb_dsc_decoder;

  typedef struct {
    string name;
    logic  rst;
    logic  en;
    logic  valid;
    logic  in;
    logic  last;
    logic  rdy;
    int    expBin;
    int    expCyc;
    int    expFin;
    int    expOvf;
  } vec_t;

  logic        gclk;
  logic        rst;
  logic        en;
  logic        snIn;
  logic        snValid;
  logic        snLast;
  logic        outReady;
  logic [16:0] cyclesOverride;
  logic [3:0]  smOverride;

  logic [15:0] binOut;
  logic [16:0] cycOut;
  logic        fin;
  logic        ovf;
  logic [15:0] smBin;
  logic [3:0]  smCyc;
  logic        smFin;
  logic        smOvf;

  int testsRun;
  int testsFailed;

  vec_t vecs[11];

  dsc_decoder dut (
    .gclk           (gclk),
    .rst            (rst),
    .en             (en),
    .sn_in          (snIn),
    .sn_valid       (snValid),
    .sn_last        (snLast),
    .cycles_override(cyclesOverride),
    .out_ready      (outReady),
    .bin_data_out   (binOut),
    .cycle_count    (cycOut),
    .op_finished    (fin),
    .count_overflow (ovf)
  );

  dsc_decoder #(
    .CNT_WIDTH(4)
  ) dutSmall (
    .gclk           (gclk),
    .rst            (rst),
    .en             (en),
    .sn_in          (snIn),
    .sn_valid       (snValid),
    .sn_last        (snLast),
    .cycles_override(smOverride),
    .out_ready      (outReady),
    .bin_data_out   (smBin),
    .cycle_count    (smCyc),
    .op_finished    (smFin),
    .count_overflow (smOvf)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  function automatic vec_t makeVec(input string name, input logic r, input logic e,
                                   input logic v, input logic i, input logic l,
                                   input logic rdy, input int eb, input int ec,
                                   input int ef, input int eo);
    vec_t t;
    t.name = name; t.rst = r; t.en = e; t.valid = v; t.in = i; t.last = l; t.rdy = rdy;
    t.expBin = eb; t.expCyc = ec; t.expFin = ef; t.expOvf = eo;
    return t;
  endfunction

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input logic i, input logic l, input logic rdy);
    rst = r; en = e; snValid = v; snIn = i; snLast = l; outReady = rdy;
    @(posedge gclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string name, input int eb, input int ec,
                          input int ef, input int eo);
    checkOutput({name, "/bin"}, int'(binOut), eb);
    checkOutput({name, "/cyc"}, int'(cycOut), ec);
    checkOutput({name, "/fin"}, int'(fin), ef);
    checkOutput({name, "/ovf"}, int'(ovf), eo);
  endtask

  initial begin
    testsRun = 0; testsFailed = 0;
    rst = 1'b1; en = 1'b0; snIn = 1'b0; snValid = 1'b0; snLast = 1'b0; outReady = 1'b0;
    cyclesOverride = '0; smOverride = '0;

    // Basic flow with valid gaps: three valid ones, last on the third.
    vecs[0]  = makeVec("v0_reset",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = makeVec("v1_start",   0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = makeVec("v2_bit1",    0, 1, 1, 1, 0, 0, 1, 1, 0, 0);
    vecs[3]  = makeVec("v3_gap",     0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    vecs[4]  = makeVec("v4_gap",     0, 1, 0, 1, 0, 0, 1, 1, 0, 0);
    vecs[5]  = makeVec("v5_bit2",    0, 1, 1, 1, 0, 0, 2, 2, 0, 0);
    vecs[6]  = makeVec("v6_last",    0, 1, 1, 1, 1, 0, 3, 3, 1, 0);
    vecs[7]  = makeVec("v7_donehold",0, 1, 1, 1, 0, 0, 3, 3, 1, 0);
    vecs[8]  = makeVec("v8_release", 0, 1, 0, 0, 0, 1, 3, 3, 0, 0);
    vecs[9]  = makeVec("v9_idle",    0, 0, 1, 1, 0, 0, 3, 3, 0, 0);
    vecs[10] = makeVec("v10_reset",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].valid, vecs[k].in,
                    vecs[k].last, vecs[k].rdy);
      checkAll(vecs[k].name, vecs[k].expBin, vecs[k].expCyc, vecs[k].expFin, vecs[k].expOvf);
    end

    // 16 bits of 1010..., last on bit 16.
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkAll("A_start", 0, 0, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0, 1, 1, logic'(i % 2), logic'(i == 16), 0);
      if (i == 15) checkAll("A_bit15", 8, 15, 0, 0);
    end
    checkAll("A_done", 8, 16, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkAll("A_release", 8, 16, 0, 0);

    // Override of 5 ends an all-ones stream; a 6th bit is ignored.
    cyclesOverride = 17'd5;
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 0);
      if (i == 4) checkAll("B_bit4", 4, 4, 0, 0);
    end
    checkAll("B_done", 5, 5, 1, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkAll("B_bit6", 5, 5, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkAll("B_release", 5, 5, 0, 0);

    // Override and last on the same bit.
    cyclesOverride = 17'd3;
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 0);
    checkAll("C_both", 2, 3, 1, 0);
    applyStimulus(0, 1, 1, 1, 1, 0);
    checkAll("C_hold", 2, 3, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkAll("C_release", 2, 3, 0, 0);

    // Override already behind the count does not terminate.
    cyclesOverride = '0;
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 1, 1, 0, 0);
    cyclesOverride = 17'd3;
    applyStimulus(0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkAll("S_past", 6, 6, 0, 0);
    applyStimulus(0, 1, 1, 0, 1, 0);
    checkAll("S_last", 6, 7, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    cyclesOverride = '0;

    // Saturation on the 4-bit-counter instance: 20 ones, last on bit 20.
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkAll("D_reset", 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) applyStimulus(0, 1, 1, 1, logic'(i == 20), 0);
    checkOutput("D_smBin", int'(smBin), 15);
    checkOutput("D_smCyc", int'(smCyc), 15);
    checkOutput("D_smFin", int'(smFin), 1);
    checkOutput("D_smOvf", int'(smOvf), 1);
    checkAll("D_big", 20, 20, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkOutput("D_smOvfHeld", int'(smOvf), 1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("D_smOvfClr", int'(smOvf), 0);
    checkOutput("D_smCycClr", int'(smCyc), 0);

    // Reset mid-stream, clean restart, then abort by dropping en.
    for (int i = 1; i <= 7; i++) applyStimulus(0, 1, 1, 1, 0, 0);
    checkAll("E_bit7", 7, 7, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 0);
    checkAll("E_rst", 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    checkAll("E_restart", 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) applyStimulus(0, 1, 1, 1, 0, 0);
    checkAll("E_bit3", 3, 3, 0, 0);
    applyStimulus(0, 0, 1, 1, 1, 0);
    checkAll("E_abort", 3, 3, 0, 0);
    applyStimulus(0, 0, 1, 1, 0, 0);
    checkAll("E_idle", 3, 3, 0, 0);

    // Long hold in DONE with out_ready low, then release.
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 1, 0);
    checkAll("F_done", 2, 2, 1, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 1, 1, logic'(i % 2), 0);
      checkAll("F_hold", 2, 2, 1, 0);
    end
    applyStimulus(0, 1, 0, 0, 0, 1);
    checkAll("F_release", 2, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
